// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bus between the LSU and the data-memory responder
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] data_addr;
  logic [3:0]  dmem_wr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        resp_err;

  modport master (
    output req_valid, data_addr, dmem_wr, wdata,
    input  req_ready, resp_valid, rdata, resp_err
  );

  modport slave (
    input  req_valid, data_addr, dmem_wr, wdata,
    output req_ready, resp_valid, rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with wait states, lane and range checks
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wr_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   cur_addr, cur_wdata;
  logic [3:0]    cur_wr;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          range_err, lane_err, acc_err;
  logic [31:0]   word_rd, rd_rot;

  function automatic logic lane_legal(input logic [3:0] be, input logic [1:0] a);
    case (be)
      4'b1111: return a == 2'd0;
      4'b0011: return a == 2'd0;
      4'b0110: return a == 2'd1;
      4'b1100: return a == 2'd2;
      4'b0001: return a == 2'd0;
      4'b0010: return a == 2'd1;
      4'b0100: return a == 2'd2;
      4'b1000: return a == 2'd3;
      default: return 1'b0;
    endcase
  endfunction

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.rdata      = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is also the acceptance edge, so use the live bus then.
  assign cur_addr  = (state == S_IDLE) ? bus.data_addr : addr_q;
  assign cur_wdata = (state == S_IDLE) ? bus.wdata     : wdata_q;
  assign cur_wr    = (state == S_IDLE) ? bus.dmem_wr   : wr_q;

  assign offset    = cur_addr - BASE_ADDR;
  assign idx       = offset[AW+1:2];
  assign range_err = (offset >= SPAN);
  assign lane_err  = (cur_wr != 4'b0000) && !lane_legal(cur_wr, cur_addr[1:0]);
  assign acc_err   = range_err || lane_err;

  assign word_rd = range_err ? 32'd0 : mem[idx];

  always_comb begin
    rd_rot = word_rd;
    case (cur_addr[1:0])
      2'd0: rd_rot = word_rd;
      2'd1: rd_rot = {word_rd[7:0],  word_rd[31:8]};
      2'd2: rd_rot = {word_rd[15:0], word_rd[31:16]};
      2'd3: rd_rot = {word_rd[23:0], word_rd[31:24]};
      default: rd_rot = word_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wr_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= bus.data_addr;
        wdata_q <= bus.wdata;
        wr_q    <= bus.dmem_wr;
      end
      if (enter_resp) begin
        rdata_q <= (acc_err || cur_wr != 4'b0000) ? 32'd0 : rd_rot;
        err_q   <= acc_err;
      end
    end
  end

  // RAM is not reset; rst_n gating keeps a request that races reset from committing.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (cur_wr[k]) begin
          mem[idx][8*k +: 8] <= cur_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule
